// File: rtl/ctl_pipe.sv
// Multi-cycle controller: fetch/decode/exec FSM driving an external regfile and ALU.
// One instruction in flight; fetch handshake is valid/ready, ALU results are sampled after ALU_LAT EXEC cycles.
package ctl_pipe_pkg;
  typedef logic [7:0] reg_t;
  typedef enum logic {ALU_OP_ADD = 1'b0, ALU_OP_SUB = 1'b1} alu_op_t;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_HLT  = 8'h01;
  localparam logic [7:0] OPC_IMOV = 8'h02;
  localparam logic [7:0] OPC_IADD = 8'h03;
  localparam logic [7:0] OPC_ISUB = 8'h04;
  localparam logic [7:0] OPC_MOV  = 8'h05;
  localparam logic [7:0] OPC_ADD  = 8'h06;
  localparam logic [7:0] OPC_SUB  = 8'h07;
  localparam logic [7:0] OPC_JMP  = 8'h08;

  localparam int PUC_EOH = 0;
endpackage

module ctl_pipe
  import ctl_pipe_pkg::*;
#(
  parameter int WORD_LEN = 64,
  parameter int N_PUC    = 2,
  parameter int PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int ALU_LAT  = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                inst_valid_i,
  input  logic [31:0]         inst_i,
  output logic                inst_ready_o,
  output logic [PC_W-1:0]     pc_o,
  output reg_t                reg_rd_a_id_o,
  output reg_t                reg_rd_b_id_o,
  input  logic [WORD_LEN-1:0] reg_a_i,
  input  logic [WORD_LEN-1:0] reg_b_i,
  output logic                reg_write_en_o,
  output reg_t                reg_id_o,
  output logic [WORD_LEN-1:0] reg_value_o,
  output logic [WORD_LEN-1:0] alu_op_a_o,
  output logic [WORD_LEN-1:0] alu_op_b_o,
  output alu_op_t             alu_opc_o,
  input  logic [WORD_LEN-1:0] alu_res_i,
  input  logic [N_PUC-1:0]    puc_i,
  input  logic                wake_i,
  output logic                halted_o,
  output logic                exc_o,
  output logic                reset_o
);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  reg_t                rid_q, rid_d;
  logic [WORD_LEN-1:0] rval_q, rval_d;
  logic [WORD_LEN-1:0] opa_q, opa_d;
  logic [WORD_LEN-1:0] opb_q, opb_d;
  alu_op_t             opc_q, opc_d;

  logic [7:0]          opcode;
  reg_t                rd, rs;
  logic [WORD_LEN-1:0] imm;
  logic [PC_W-1:0]     jmp_off;
  logic                unused_puc;

  assign opcode  = inst_q[7:0];
  assign rd      = inst_q[15:8];
  assign rs      = inst_q[23:16];
  assign imm     = WORD_LEN'(inst_q[31:16]);
  // 24-bit signed word offset, scaled to bytes and wrapped to the PC width
  assign jmp_off = PC_W'({{42{inst_q[31]}}, inst_q[31:8], 2'b00});
  assign unused_puc = ^puc_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rid_q   <= '0;
      rval_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= ALU_OP_ADD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rid_q   <= rid_d;
      rval_q  <= rval_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    rid_d   = rid_q;
    rval_d  = rval_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    case (state_q)
      S_FETCH: begin
        if (inst_valid_i) begin
          inst_d  = inst_i;
          pc_d    = pc_q + PC_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OPC_NOP: ;
          OPC_HLT: state_d = S_HALT;
          OPC_IMOV, OPC_MOV: begin
            we_d   = 1'b1;
            rid_d  = rd;
            rval_d = (opcode == OPC_IMOV) ? imm : reg_b_i;
          end
          OPC_IADD, OPC_ISUB, OPC_ADD, OPC_SUB: begin
            opa_d   = reg_a_i;
            opb_d   = (opcode == OPC_IADD || opcode == OPC_ISUB) ? imm : reg_b_i;
            opc_d   = (opcode == OPC_ISUB || opcode == OPC_SUB) ? ALU_OP_SUB : ALU_OP_ADD;
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = S_EXEC;
          end
          // pc already points past the jump, so rewind before applying the offset
          OPC_JMP: pc_d = pc_q - PC_W'(4) + jmp_off;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          we_d    = 1'b1;
          rid_d   = rd;
          rval_d  = alu_res_i;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (wake_i) state_d = S_FETCH;
      end
      S_FAULT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    inst_ready_o = (state_q == S_FETCH);
    halted_o     = (state_q == S_HALT) || (state_q == S_FAULT);
    exc_o        = (state_q == S_FAULT);
    reset_o      = (state_q == S_FAULT) && !puc_i[PUC_EOH];
  end

  assign pc_o           = pc_q;
  assign reg_rd_a_id_o  = rd;
  assign reg_rd_b_id_o  = rs;
  assign reg_write_en_o = we_q;
  assign reg_id_o       = rid_q;
  assign reg_value_o    = rval_q;
  assign alu_op_a_o     = opa_q;
  assign alu_op_b_o     = opb_q;
  assign alu_opc_o      = opc_q;
endmodule

// File: tb/tb_ctl_pipe.sv
// Directed bench for ctl_pipe with a behavioural regfile and a 3-stage ALU.
module tb_ctl_pipe;
  import ctl_pipe_pkg::*;

  localparam int WL = 64;
  localparam int PW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          inst_valid_i = 1'b0;
  logic [31:0]   inst_i = '0;
  logic          inst_ready_o;
  logic [PW-1:0] pc_o;
  reg_t          reg_rd_a_id_o, reg_rd_b_id_o, reg_id_o;
  logic [WL-1:0] reg_a_i, reg_b_i, reg_value_o, alu_op_a_o, alu_op_b_o, alu_res_i;
  logic          reg_write_en_o;
  alu_op_t       alu_opc_o;
  logic [1:0]    puc_i = 2'b00;
  logic          wake_i = 1'b0;
  logic          halted_o, exc_o, reset_o;

  int checks = 0;
  int errors = 0;

  ctl_pipe #(.WORD_LEN(WL), .N_PUC(2), .PC_W(PW), .RESET_PC(8'h00), .ALU_LAT(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .inst_ready_o(inst_ready_o), .pc_o(pc_o),
    .reg_rd_a_id_o(reg_rd_a_id_o), .reg_rd_b_id_o(reg_rd_b_id_o),
    .reg_a_i(reg_a_i), .reg_b_i(reg_b_i),
    .reg_write_en_o(reg_write_en_o), .reg_id_o(reg_id_o), .reg_value_o(reg_value_o),
    .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o), .alu_opc_o(alu_opc_o),
    .alu_res_i(alu_res_i), .puc_i(puc_i), .wake_i(wake_i),
    .halted_o(halted_o), .exc_o(exc_o), .reset_o(reset_o)
  );

  always #5 clk_i = ~clk_i;

  logic [WL-1:0] rf [256];
  initial for (int i = 0; i < 256; i++) rf[i] = '0;
  assign reg_a_i = rf[reg_rd_a_id_o];
  assign reg_b_i = rf[reg_rd_b_id_o];
  always @(posedge clk_i) if (reg_write_en_o) rf[reg_id_o] <= reg_value_o;

  // result valid three cycles after the operands change
  logic [WL-1:0] alu_p1 = '0, alu_p2 = '0;
  always @(posedge clk_i) begin
    alu_p1 <= (alu_opc_o == ALU_OP_SUB) ? alu_op_a_o - alu_op_b_o : alu_op_a_o + alu_op_b_o;
    alu_p2 <= alu_p1;
  end
  assign alu_res_i = alu_p2;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] w);
    int n = 0;
    while (!inst_ready_o && n < 50) begin
      step();
      n++;
    end
    chk("issue_ready", 64'(inst_ready_o), 64'd1);
    inst_valid_i = 1'b1;
    inst_i = w;
    step();
    inst_valid_i = 1'b0;
  endtask

  initial begin
    int hcnt;
    step();
    step();
    reset_i = 1'b0;
    chk("rst_pc", 64'(pc_o), 64'h00);
    chk("rst_ready", 64'(inst_ready_o), 64'd1);
    chk("rst_flags", {61'd0, halted_o, exc_o, reset_o}, 64'd0);
    chk("rst_we", 64'(reg_write_en_o), 64'd0);
    chk("rst_val", reg_value_o, 64'd0);
    chk("rst_alu", {alu_op_a_o[31:0], 31'd0, alu_opc_o}, 64'd0);

    // IMOV r1,0x1234
    issue(32'h1234_0102);
    chk("imov_busy", {62'd0, inst_ready_o, reg_write_en_o}, 64'd0);
    step();
    chk("imov_we", 64'(reg_write_en_o), 64'd1);
    chk("imov_id", 64'(reg_id_o), 64'd1);
    chk("imov_val", reg_value_o, 64'h1234);
    chk("imov_pc", 64'(pc_o), 64'h04);
    step();
    chk("imov_pulse", 64'(reg_write_en_o), 64'd0);

    // HLT, wake after 10 halted cycles
    issue(32'h0000_0001);
    step();
    hcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (halted_o && !inst_ready_o) hcnt++;
      if (i == 9) wake_i = 1'b1;
      step();
    end
    wake_i = 1'b0;
    chk("halt_cycles", 64'(hcnt), 64'd10);
    chk("wake_state", {62'd0, halted_o, inst_ready_o}, 64'd1);
    chk("wake_pc", 64'(pc_o), 64'h08);

    // IMOV r1,5 then IADD r1,7 over three EXEC cycles
    issue(32'h0005_0102);
    step();
    issue(32'h0007_0103);
    step();
    chk("iadd_ops", {alu_op_a_o[31:0], alu_op_b_o[31:0]}, {32'd5, 32'd7});
    chk("iadd_opc", 64'(alu_opc_o), 64'(ALU_OP_ADD));
    step();
    chk("iadd_ex2", {62'd0, reg_write_en_o, inst_ready_o}, 64'd0);
    step();
    chk("iadd_ex3", {62'd0, reg_write_en_o, inst_ready_o}, 64'd0);
    step();
    chk("iadd_we", 64'(reg_write_en_o), 64'd1);
    chk("iadd_val", reg_value_o, 64'd12);

    // ISUB r1,13 wraps to all ones
    issue(32'h000D_0104);
    step();
    chk("isub_opc", 64'(alu_opc_o), 64'(ALU_OP_SUB));
    step();
    step();
    step();
    chk("isub_we", 64'(reg_write_en_o), 64'd1);
    chk("isub_val", reg_value_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // MOV r2,r1 and ADD r2,r1 issued back to back with dependencies
    issue(32'h0001_0205);
    step();
    chk("mov_val", reg_value_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mov_id", 64'(reg_id_o), 64'd2);
    issue(32'h0001_0206);
    step();
    step();
    step();
    step();
    chk("add_val", reg_value_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_pc", 64'(pc_o), 64'h1C);

    // JMP +0x38 words to 0xFC, NOP wraps pc to 0
    issue(32'h0000_3808);
    step();
    chk("jmp_fc", 64'(pc_o), 64'hFC);
    issue(32'h0000_0000);
    chk("nop_wrap", 64'(pc_o), 64'h00);
    step();
    issue(32'h0000_0408);
    step();
    chk("jmp_10", 64'(pc_o), 64'h10);
    issue(32'hFFFF_FF08);
    step();
    chk("jmp_neg", 64'(pc_o), 64'h0C);

    // reset in the middle of EXEC
    issue(32'h0007_0103);
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_rst_we", 64'(reg_write_en_o), 64'd0);
    chk("mid_rst_pc", 64'(pc_o), 64'h00);
    chk("mid_rst_ready", 64'(inst_ready_o), 64'd1);
    step();
    chk("mid_rst_nopulse", 64'(reg_write_en_o), 64'd0);

    // undefined opcode, exception requests reset
    puc_i = 2'b00;
    issue(32'h0000_00FF);
    step();
    chk("flt0_flags", {61'd0, halted_o, exc_o, reset_o}, 64'd7);
    wake_i = 1'b1;
    step();
    step();
    step();
    wake_i = 1'b0;
    chk("flt0_held", {60'd0, inst_ready_o, halted_o, exc_o, reset_o}, 64'd7);
    chk("flt0_pc", 64'(pc_o), 64'h04);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("flt0_clear", {60'd0, inst_ready_o, halted_o, exc_o, reset_o}, 64'd8);

    // undefined opcode, exception halts
    puc_i = 2'b01;
    issue(32'h0000_00FF);
    step();
    chk("flt1_flags", {61'd0, halted_o, exc_o, reset_o}, 64'd6);
    wake_i = 1'b1;
    step();
    step();
    wake_i = 1'b0;
    chk("flt1_wake_ign", {60'd0, inst_ready_o, halted_o, exc_o, reset_o}, 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctl_pipe.md
CTL_PIPE -- requirements
Module: ctl_pipe

Interface
REQ-001 Param WORD_LEN, 64, datapath/register width.
REQ-002 Param N_PUC, 2, power-up contract bit count.
REQ-003 Param PC_W, 32, program counter width.
REQ-004 Param RESET_PC, 0, PC value loaded on reset.
REQ-005 Param ALU_LAT, 1 (>=1), cycles from operands driven to alu_res_i valid.
REQ-006 clk_i  in  1  sole clock; all state updates on posedge clk_i.
REQ-007 reset_i  in  1  synchronous active-high reset, sampled on posedge clk_i.
REQ-008 inst_valid_i  in  1; inst_i  in  32  fetch unit instruction and its valid flag.
REQ-009 inst_ready_o  out  1  controller accepts an instruction this cycle.
REQ-010 pc_o  out  PC_W  program counter to fetch unit.
REQ-011 reg_rd_a_id_o, reg_rd_b_id_o  out  reg_t  regfile read selects; reg_a_i, reg_b_i  in  WORD_LEN  combinational read data.
REQ-012 reg_write_en_o  out  1; reg_id_o  out  reg_t; reg_value_o  out  WORD_LEN  regfile write port.
REQ-013 alu_op_a_o, alu_op_b_o  out  WORD_LEN; alu_opc_o  out  alu_op_t; alu_res_i  in  WORD_LEN.
REQ-014 puc_i  in  N_PUC  power-up contract; bit PUC_EOH selects halt (1) vs reset (0) on exception.
REQ-015 wake_i  in  1  resumes execution from HALT.
REQ-016 halted_o, exc_o, reset_o  out  1  halted, exception-latched, reset-request flags.

Function
REQ-017 Format: [7:0] opcode, [15:8] rd, [23:16] rs, [31:16] imm16; imm zero-extended to WORD_LEN; JMP offset = sign-extended [31:8].
REQ-018 Opcodes (inst.svh): NOP, HLT, IMOV, IADD, ISUB, MOV (rd<=rs), ADD (rd<=rd+rs), SUB (rd<=rd-rs), JMP; all else undefined.
REQ-019 States FETCH, DECODE, EXEC, HALT, FAULT; only FETCH asserts inst_ready_o.
REQ-020 FETCH: on inst_valid_i&&inst_ready_o latch inst_i, pc <= pc+4 (mod 2^PC_W), go DECODE; else hold.
REQ-021 reg_rd_a_id_o = latched rd, reg_rd_b_id_o = latched rs, combinationally, in every state.
REQ-022 DECODE NOP -> FETCH; HLT -> HALT; undefined -> FAULT.
REQ-023 DECODE IMOV/MOV: reg_id_o<=rd, reg_value_o<=imm/reg_b_i, reg_write_en_o<=1, -> FETCH.
REQ-024 DECODE IADD/ISUB/ADD/SUB: alu_op_a_o<=reg_a_i, alu_op_b_o<=imm or reg_b_i, alu_opc_o<=ALU_OP_ADD/ALU_OP_SUB, counter<=ALU_LAT, -> EXEC.
REQ-025 EXEC: decrement counter; on last EXEC cycle capture alu_res_i into reg_value_o, reg_id_o<=rd, reg_write_en_o<=1, -> FETCH; ALU ops occupy exactly ALU_LAT EXEC cycles.
REQ-026 DECODE JMP: pc <= (pc-4)+(offset<<2), truncated to PC_W, -> FETCH.
REQ-027 reg_write_en_o is a single-cycle pulse, high only in the FETCH cycle after a write; cleared all other cycles.
REQ-028 Write commits before next DECODE; back-to-back dependent instructions need no stall.
REQ-029 HALT: halted_o=1, pc frozen; wake_i -> FETCH next cycle at current pc.
REQ-030 FAULT: exc_o=1, halted_o=1, pc frozen, wake_i ignored; reset_o=1 iff puc_i[PUC_EOH]==0, held until reset_i.
REQ-031 alu_op_*_o, alu_opc_o hold last values outside DECODE.

Reset
REQ-032 reset_i high: state FETCH, pc=RESET_PC, inst=0, counter=0, all 1-bit outputs 0, reg_value_o=0, reg_id_o=0, alu_op_a_o=alu_op_b_o=0, alu_opc_o=ALU_OP_ADD.
REQ-033 reset_i overrides every state incl. mid-EXEC and FAULT; no write pulse issued for an aborted instruction.

Verification
REQ-034 Reset, IMOV r1,0x1234 valid -> one reg_write_en_o pulse, reg_id_o=1, reg_value_o=0x1234, pc_o=4.
REQ-035 ALU_LAT=3, r1=5, IADD r1,7 -> exactly 3 EXEC cycles then write r1=12; ISUB r1,13 -> write 2^WORD_LEN-1.
REQ-036 HLT then wake_i after 10 cycles -> halted_o high 10 cycles, inst_ready_o low, resume fetch at pc=8.
REQ-037 Undefined opcode 0xFF: puc_i[PUC_EOH]=0 -> exc_o=1, reset_o=1 held; PUC_EOH=1 -> exc_o=1, reset_o=0, wake_i ignored.
REQ-038 PC_W=8, pc=0xFC, NOP -> pc_o=0x00; JMP offset -1 at pc=0x10 -> pc_o=0x0C.
REQ-039 reset_i asserted during EXEC -> no write pulse, pc_o=RESET_PC next cycle, inst_ready_o=1.
